// File: rtl/dbg_bridge_pkg.sv
// Shared types and constants for the sysclk-side debug command bridge.
package dbg_bridge_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/dbg_toggle_sync.sv
// Toggle-to-pulse synchroniser: SYNC_STAGES flops, an edge flop, then a
// registered XOR that yields a 1-clk pulse per toggle edge.
module dbg_toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tgl_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   pulse_q, pulse_d;

  // Registering the XOR places the pulse SYNC_STAGES+1 clk after the toggle edge.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], tgl_in};
    edge_d  = sync_q[SYNC_STAGES-1];
    pulse_d = sync_q[SYNC_STAGES-1] ^ edge_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/debug_cmd_bridge.sv
// Sysclk-side JTAG debug command bridge: synchronises update-DR/IR toggles and
// routes one captured command at a time to NUM_CH targets. Optional timeout via DBG_BRIDGE_TIMEOUT_EN.
module debug_cmd_bridge
  import dbg_bridge_pkg::*;
#(
  parameter  int unsigned DATA_W      = 38,
  parameter  int unsigned IR_W        = 2,
  parameter  int unsigned NUM_CH      = 1,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned TIMEOUT_W   = 8,
  localparam int unsigned CH_W        = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              udr_tgl,
  input  logic              uir_tgl,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [DATA_W-1:0] sr,
  output logic [DATA_W-1:0] jdo,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [NUM_CH-1:0] cmd_valid,
  input  logic [NUM_CH-1:0] cmd_ready,
  output logic              uir_pulse,
  output logic              busy,
  output logic              overrun,
  output logic              bad_ch,
  output logic [NUM_CH-1:0] timeout
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_W < 1) begin : g_bad_param
    $error("debug_cmd_bridge: SYNC_STAGES must be 2..4 and TIMEOUT_W >= 1");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] jdo_q, jdo_d;
  logic [IR_W-1:0]   cmd_ir_q, cmd_ir_d;
  logic [NUM_CH-1:0] cmd_valid_q, cmd_valid_d;
  logic              overrun_q, overrun_d;
  logic              bad_ch_q, bad_ch_d;
  logic              udr_evt, uir_evt;
  logic              ch_ok, xfer, tmo_hit;

  dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk    (clk),
    .reset  (reset),
    .tgl_in (udr_tgl),
    .pulse  (udr_evt)
  );

  dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk    (clk),
    .reset  (reset),
    .tgl_in (uir_tgl),
    .pulse  (uir_evt)
  );

  assign ch_ok = (32'(ch_sel) < NUM_CH);
  assign xfer  = (state_q == ST_HOLD) && ((cmd_valid_q & cmd_ready) != '0);

  always_comb begin
    state_d     = state_q;
    jdo_d       = jdo_q;
    cmd_ir_d    = cmd_ir_q;
    cmd_valid_d = cmd_valid_q;
    overrun_d   = uir_evt ? 1'b0 : overrun_q;
    bad_ch_d    = uir_evt ? 1'b0 : bad_ch_q;
    unique case (state_q)
      ST_IDLE: begin
        if (udr_evt) begin
          if (ch_ok) begin
            jdo_d       = sr;
            cmd_ir_d    = ir_in;
            cmd_valid_d = NUM_CH'(1) << ch_sel;
            state_d     = ST_HOLD;
          end else begin
            bad_ch_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // A new event while a command is pending is dropped, even on the transfer cycle.
        if (udr_evt) begin
          overrun_d = 1'b1;
        end
        if (xfer || tmo_hit) begin
          cmd_valid_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      jdo_q       <= '0;
      cmd_ir_q    <= '0;
      cmd_valid_q <= '0;
      overrun_q   <= 1'b0;
      bad_ch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      jdo_q       <= jdo_d;
      cmd_ir_q    <= cmd_ir_d;
      cmd_valid_q <= cmd_valid_d;
      overrun_q   <= overrun_d;
      bad_ch_q    <= bad_ch_d;
    end
  end

`ifdef DBG_BRIDGE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [NUM_CH-1:0]    timeout_q, timeout_d;

  // Counter idles at zero so it is already cleared on the first HOLD cycle.
  always_comb begin
    tmo_cnt_d = (state_q == ST_HOLD) ? tmo_cnt_q + TIMEOUT_W'(1) : '0;
    tmo_hit   = (state_q == ST_HOLD) && !xfer && (&tmo_cnt_q);
    timeout_d = uir_evt ? '0 : timeout_q;
    if (tmo_hit) begin
      timeout_d = timeout_d | cmd_valid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      timeout_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = '0;
`endif

  assign jdo       = jdo_q;
  assign cmd_ir    = cmd_ir_q;
  assign cmd_valid = cmd_valid_q;
  assign uir_pulse = uir_evt;
  assign busy      = (state_q == ST_HOLD);
  assign overrun   = overrun_q;
  assign bad_ch    = bad_ch_q;

endmodule
